// File: rtl/mem_stage_pkg.sv
// Shared encodings, bus widths and the execute-to-memory bus layout for mem_stage.
// The CSR path is only present when MS_CSR_EN is defined.
package mem_stage_pkg;

  localparam int EXE_MEM_BUS_W = 187;
  localparam int MEM_WB_BUS_W  = 70;
  localparam int MS_ID_BUS_W   = 38;

  localparam logic [2:0] WB_SEL_ALU = 3'd0;
  localparam logic [2:0] WB_SEL_MEM = 3'd1;
  localparam logic [2:0] WB_SEL_PC4 = 3'd2;
  localparam logic [2:0] WB_SEL_CSR = 3'd3;

  localparam logic [3:0] CSR_CMD_X = 4'd0;
  localparam logic [3:0] CSR_CMD_W = 4'd1;
  localparam logic [3:0] CSR_CMD_S = 4'd2;
  localparam logic [3:0] CSR_CMD_C = 4'd3;

  // Field order matches the execute stage's packing, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1;
    logic [31:0] load_data;
  } exe_mem_bus_t;

endpackage

// File: rtl/mem_stage_csr_alu.sv
// CSR read-modify-write operator: turns a command, the old CSR value and the
// operand into a write enable and the new CSR value.
module csr_alu
  import mem_stage_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [31:0] rdata,
  input  logic [31:0] op1,
  output logic        we,
  output logic [31:0] wdata
);

  always_comb begin
    we    = 1'b0;
    wdata = '0;
    case (cmd)
      CSR_CMD_W: begin
        we    = 1'b1;
        wdata = op1;
      end
      CSR_CMD_S: begin
        we    = 1'b1;
        wdata = rdata | op1;
      end
      CSR_CMD_C: begin
        we    = 1'b1;
        wdata = rdata & ~op1;
      end
      default: begin
        we    = 1'b0;
        wdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues stores, performs CSR RMW and selects the
// writeback value. Optional CSR path is enabled by defining MS_CSR_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus_in,
  input  logic                     es_to_ms_valid,
  output logic                     ms_allowin,
  input  logic                     ws_allowin,
  output logic                     ms_to_ws_valid,
  output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus,
  output logic [MS_ID_BUS_W-1:0]   ms_id_data_bus,
  output logic                     dmem_we,
  output logic [XLEN-1:0]          dmem_waddr,
  output logic [XLEN-1:0]          dmem_wdata,
  input  logic                     dmem_wready,
  input  logic [XLEN-1:0]          csr_rdata,
  output logic                     csr_we,
  output logic [11:0]              csr_waddr,
  output logic [XLEN-1:0]          csr_wdata
);

  exe_mem_bus_t    bus_q;
  logic            ms_valid;
  logic            store_done;
  logic            is_store;
  logic            ms_ready_go;
  logic            leave;
  logic            rd_wen_out;
  logic [XLEN-1:0] csr_old;
  logic [XLEN-1:0] wb_value;

  // Once a store has been accepted it no longer holds the stage, even while
  // writeback is stalled, and it must not be issued a second time.
  assign is_store       = ms_valid && bus_q.mem_we;
  assign dmem_we        = is_store && !store_done;
  assign ms_ready_go    = !is_store || store_done || dmem_wready;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign leave          = ms_to_ws_valid && ws_allowin;
  assign dmem_waddr     = bus_q.alu_result;
  assign dmem_wdata     = bus_q.store_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_valid <= 1'b0;
      bus_q    <= '0;
    end else begin
      if (ms_allowin)
        ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin)
        bus_q <= exe_mem_bus_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      store_done <= 1'b0;
    else if (leave)
      store_done <= 1'b0;
    else if (dmem_we && dmem_wready)
      store_done <= 1'b1;
  end

`ifdef MS_CSR_EN
  logic        csr_op_we;
  logic [31:0] csr_op_wdata;
  logic        unused_ok;

  csr_alu u_csr_alu (
    .cmd   (bus_q.csr_cmd),
    .rdata (csr_rdata),
    .op1   (bus_q.op1),
    .we    (csr_op_we),
    .wdata (csr_op_wdata)
  );

  // The write commits only on the cycle the instruction hands off to writeback.
  assign csr_we    = csr_op_we && leave;
  assign csr_waddr = bus_q.csr_addr;
  assign csr_wdata = csr_op_wdata;
  assign csr_old   = csr_rdata;
  assign unused_ok = bus_q.mem_re;
`else
  logic unused_ok;

  assign csr_we    = 1'b0;
  assign csr_waddr = '0;
  assign csr_wdata = '0;
  assign csr_old   = '0;
  assign unused_ok = ^{bus_q.mem_re, bus_q.csr_cmd, bus_q.csr_addr, bus_q.op1, csr_rdata};
`endif

  always_comb begin
    wb_value = '0;
    case (bus_q.wb_sel)
      WB_SEL_ALU: wb_value = bus_q.alu_result;
      WB_SEL_MEM: wb_value = bus_q.load_data;
      WB_SEL_PC4: wb_value = bus_q.pc + 32'd4;
      WB_SEL_CSR: wb_value = csr_old;
      default:    wb_value = '0;
    endcase
  end

  assign rd_wen_out     = bus_q.rd_wen && ms_valid;
  assign mem_wb_bus     = {wb_value, bus_q.rd, rd_wen_out, bus_q.pc};
  assign ms_id_data_bus = {wb_value, rd_wen_out, bus_q.rd};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, store/reset corner
// sequences and a randomized run against a behavioural model.
module tb_mem_stage;

`ifdef MS_CSR_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [186:0] exe_mem_bus_in;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [69:0]  mem_wb_bus;
  logic [37:0]  ms_id_data_bus;
  logic         dmem_we;
  logic [31:0]  dmem_waddr;
  logic [31:0]  dmem_wdata;
  logic         dmem_wready;
  logic [31:0]  csr_rdata;
  logic         csr_we;
  logic [11:0]  csr_waddr;
  logic [31:0]  csr_wdata;

  int tests;
  int fails;
  int writes;

  mem_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .exe_mem_bus_in (exe_mem_bus_in),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allowin     (ms_allowin),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .mem_wb_bus     (mem_wb_bus),
    .ms_id_data_bus (ms_id_data_bus),
    .dmem_we        (dmem_we),
    .dmem_waddr     (dmem_waddr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wready    (dmem_wready),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  wb_sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic [31:0] csr_in;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] exp_wb;
    logic        exp_csr_we;
    logic [31:0] exp_csr_wdata;
  } vec_t;

  function automatic logic [186:0] pack_bus(
    input logic [31:0] alu, input logic [4:0] rd, input logic rd_wen,
    input logic mem_we, input logic mem_re, input logic [2:0] wb_sel,
    input logic [31:0] pc, input logic [31:0] sd, input logic [3:0] cmd,
    input logic [11:0] caddr, input logic [31:0] op1, input logic [31:0] ld);
    return {alu, rd, rd_wen, mem_we, mem_re, wb_sel, pc, sd, cmd, caddr, op1, ld};
  endfunction

  function automatic logic [31:0] model_wb(input logic [186:0] b, input logic [31:0] csr_in);
    case (b[146:144])
      3'd0:    return b[186:155];
      3'd1:    return b[31:0];
      3'd2:    return b[143:112] + 32'd4;
      3'd3:    return CSR_ON ? csr_in : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_csr_wdata(input logic [3:0] cmd, input logic [31:0] old,
                                                  input logic [31:0] op1);
    case (cmd)
      4'd1:    return op1;
      4'd2:    return old | op1;
      4'd3:    return old & ~op1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample_write();
    if (dmem_we && dmem_wready) writes++;
  endtask

  task automatic apply_stimulus(input logic [186:0] b, input logic valid, input logic wsa,
                                input logic wr, input logic [31:0] csr_in);
    exe_mem_bus_in = b;
    es_to_ms_valid = valid;
    ws_allowin     = wsa;
    dmem_wready    = wr;
    csr_rdata      = csr_in;
  endtask

  vec_t vecs[$];

  initial begin
    logic [186:0] b;
    logic         m_valid, m_done, st, exp_we, go, exp_out, exp_allow, leave, exp_cwe;
    logic [186:0] m_bus;
    int           m_writes;

    tests = 0; fails = 0; writes = 0;
    rst = 1'b1;
    apply_stimulus('0, 1'b0, 1'b1, 1'b1, 32'd0);

    vecs.push_back('{"alu_op",  3'd0, 32'h1234, 32'h0, 32'h40, 32'h0, 4'd0, 32'h0, 32'h1234, 1'b0, 32'h0});
    vecs.push_back('{"load",    3'd1, 32'h8, 32'hCAFEF00D, 32'h44, 32'h0, 4'd0, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{"pc4",     3'd2, 32'h0, 32'h0, 32'h1000, 32'h0, 4'd0, 32'h0, 32'h1004, 1'b0, 32'h0});
    vecs.push_back('{"jal_wrap",3'd2, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{"csrrs",   3'd3, 32'h0, 32'h0, 32'h50, 32'h0F, 4'd2, 32'hF0,
                     CSR_ON ? 32'h0F : 32'h0, CSR_ON, 32'hFF});
    vecs.push_back('{"csrrc",   3'd3, 32'h0, 32'h0, 32'h54, 32'hFF00FF00, 4'd3, 32'h0F000F00,
                     CSR_ON ? 32'hFF00FF00 : 32'h0, CSR_ON, 32'hF000F000});
    vecs.push_back('{"csrrw",   3'd0, 32'h55, 32'h0, 32'h58, 32'h1, 4'd1, 32'hABCD, 32'h55, CSR_ON, 32'hABCD});
    vecs.push_back('{"sel5",    3'd5, 32'h77, 32'h66, 32'h5C, 32'h1, 4'd4, 32'h9, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{"sel7",    3'd7, 32'h99, 32'h88, 32'h60, 32'h2, 4'd0, 32'h9, 32'h0, 1'b0, 32'h0});

    // Reset state while rst is held
    #2;
    check_output("rst_allowin", ms_allowin, 1);
    check_output("rst_valid", ms_to_ws_valid, 0);
    check_output("rst_dmem_we", dmem_we, 0);
    check_output("rst_csr_we", csr_we, 0);
    check_output("rst_mem_wb_bus", mem_wb_bus, 0);
    check_output("rst_id_bus", ms_id_data_bus, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table, one instruction per entry
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      b = pack_bus(vecs[i].alu, 5'(5 + i), 1'b1, 1'b0, 1'b0, vecs[i].wb_sel, vecs[i].pc,
                   32'h0, vecs[i].cmd, 12'h300 + 12'(i), vecs[i].op1, vecs[i].ld);
      apply_stimulus(b, 1'b1, 1'b1, 1'b1, vecs[i].csr_in);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1;
      check_output({vecs[i].name, "_valid"}, ms_to_ws_valid, 1);
      check_output({vecs[i].name, "_wb"}, mem_wb_bus[69:38], vecs[i].exp_wb);
      check_output({vecs[i].name, "_fwd_wb"}, ms_id_data_bus[37:6], vecs[i].exp_wb);
      check_output({vecs[i].name, "_rd"}, mem_wb_bus[37:33], 5 + i);
      check_output({vecs[i].name, "_rd_wen"}, ms_id_data_bus[5], 1);
      check_output({vecs[i].name, "_csr_we"}, csr_we, vecs[i].exp_csr_we);
      if (vecs[i].exp_csr_we) begin
        check_output({vecs[i].name, "_csr_wdata"}, csr_wdata, vecs[i].exp_csr_wdata);
        check_output({vecs[i].name, "_csr_waddr"}, csr_waddr, 12'h300 + 12'(i));
      end
      @(negedge clk);
      #1;
      check_output({vecs[i].name, "_csr_one_pulse"}, csr_we, 0);
    end

    // Store stalled by memory for 3 cycles
    @(negedge clk);
    writes = 0;
    apply_stimulus(pack_bus(32'h100, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h70, 32'hDEADBEEF,
                            4'd0, 12'h0, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      dmem_wready = (c == 3);
      #1;
      sample_write();
      check_output("stall_dmem_we", dmem_we, 1);
      check_output("stall_allowin", ms_allowin, c == 3);
      check_output("stall_addr", dmem_waddr, 32'h100);
      check_output("stall_data", dmem_wdata, 32'hDEADBEEF);
    end
    @(negedge clk);
    #1;
    sample_write();
    check_output("stall_we_after", dmem_we, 0);
    check_output("stall_write_count", writes, 1);

    // Store accepted while writeback stalls for 2 cycles
    @(negedge clk);
    writes = 0;
    apply_stimulus(pack_bus(32'h200, 5'd3, 1'b0, 1'b1, 1'b0, 3'd0, 32'h74, 32'h12345678,
                            4'd0, 12'h0, 32'h0, 32'h0), 1'b1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    sample_write();
    check_output("wsstall_we_first", dmem_we, 1);
    check_output("wsstall_allowin", ms_allowin, 0);
    @(negedge clk);
    #1;
    sample_write();
    check_output("wsstall_we_after_accept", dmem_we, 0);
    check_output("wsstall_out_valid", ms_to_ws_valid, 1);
    check_output("wsstall_still_held", ms_allowin, 0);
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    sample_write();
    check_output("wsstall_we_drain", dmem_we, 0);
    @(negedge clk);
    #1;
    check_output("wsstall_write_count", writes, 1);
    check_output("wsstall_left", ms_to_ws_valid, 0);

    // Reset asserted in the middle of a store stall
    @(negedge clk);
    apply_stimulus(pack_bus(32'h300, 5'd4, 1'b1, 1'b1, 1'b0, 3'd0, 32'h78, 32'h1,
                            4'd0, 12'h0, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    check_output("rststall_we_before", dmem_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("rststall_we", dmem_we, 0);
    check_output("rststall_valid", ms_to_ws_valid, 0);
    check_output("rststall_allowin", ms_allowin, 1);
    check_output("rststall_bus", mem_wb_bus, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the behavioural model
    m_valid = 1'b0; m_done = 1'b0; m_bus = '0; m_writes = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      b = pack_bus($urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
                   3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom_range(0, 5)),
                   12'($urandom), $urandom, $urandom);
      apply_stimulus(b, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom);
      #1;
      st        = m_valid && m_bus[148];
      exp_we    = st && !m_done;
      go        = !st || m_done || dmem_wready;
      exp_out   = m_valid && go;
      exp_allow = !m_valid || (go && ws_allowin);
      leave     = exp_out && ws_allowin;
      exp_cwe   = CSR_ON && leave && (m_bus[79:76] inside {4'd1, 4'd2, 4'd3});

      check_output("rnd_allowin", ms_allowin, exp_allow);
      check_output("rnd_out_valid", ms_to_ws_valid, exp_out);
      check_output("rnd_dmem_we", dmem_we, exp_we);
      check_output("rnd_rd_wen", mem_wb_bus[32], m_valid && m_bus[149]);
      check_output("rnd_fwd_rd_wen", ms_id_data_bus[5], m_valid && m_bus[149]);
      check_output("rnd_csr_we", csr_we, exp_cwe);
      if (m_valid) begin
        check_output("rnd_wb", mem_wb_bus[69:38], model_wb(m_bus, csr_rdata));
        check_output("rnd_fwd_wb", ms_id_data_bus[37:6], model_wb(m_bus, csr_rdata));
        check_output("rnd_rd", mem_wb_bus[37:33], m_bus[154:150]);
        check_output("rnd_pc", mem_wb_bus[31:0], m_bus[143:112]);
      end
      if (exp_we) begin
        check_output("rnd_waddr", dmem_waddr, m_bus[186:155]);
        check_output("rnd_wdata", dmem_wdata, m_bus[111:80]);
      end
      if (exp_cwe) begin
        check_output("rnd_csr_waddr", csr_waddr, m_bus[75:64]);
        check_output("rnd_csr_wdata", csr_wdata, model_csr_wdata(m_bus[79:76], csr_rdata, m_bus[63:32]));
      end

      if (dmem_we && dmem_wready) m_writes++;
      if (leave) begin
        check_output("rnd_writes_per_insn", m_writes, m_bus[148] ? 1 : 0);
        m_writes = 0;
      end
      if (exp_we && dmem_wready) m_done = 1'b1;
      if (leave) m_done = 1'b0;
      if (exp_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) m_bus = exe_mem_bus_in;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that receives the 187-bit execute-to-memory bus over the valid/allowin handshake. Sits between the execute stage and writeback. Issues stores to data memory, performs the CSR read-modify-write, and selects the writeback value. Also drives the forwarding bus back to decode and the memory-to-writeback bus.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `exe_mem_bus_in` in 187: MSB→LSB {alu_result 32, rd 5, rd_wen 1, mem_we 1, mem_re 1, wb_sel 3, pc 32, store_data 32, csr_cmd 4, csr_addr 12, op1 32, load_data 32}.
- `es_to_ms_valid` in 1: execute stage holds a valid instruction.
- `ms_allowin` out 1: this stage accepts a new instruction this cycle.
- `ws_allowin` in 1: writeback stage accepts.
- `ms_to_ws_valid` out 1: this stage presents a completed instruction.
- `mem_wb_bus` out 70: {wb_value 32, rd 5, rd_wen 1, pc 32}.
- `ms_id_data_bus` out 38: {wb_value 32, rd_wen 1, rd 5}, forwarding to decode.
- `dmem_we` out 1: store request.
- `dmem_waddr` out 32: store address.
- `dmem_wdata` out 32: store data.
- `dmem_wready` in 1: memory accepts the store this cycle.
- `csr_rdata` in 32: CSR read data for the latched `csr_addr`.
- `csr_we` out 1: CSR write strobe.
- `csr_waddr` out 12: CSR write address.
- `csr_wdata` out 32: CSR write data.

## Operation
- Pipeline register: `ms_valid` plus a 187-bit bus register.
  - When `ms_allowin`, `ms_valid` ← `es_to_ms_valid`.
  - The bus register loads only when `es_to_ms_valid && ms_allowin`.
- `ms_ready_go` = !(ms_valid && mem_we) || dmem_wready.
- `ms_allowin` = !ms_valid || (ms_ready_go && ws_allowin).
- `ms_to_ws_valid` = ms_valid && ms_ready_go.
- Store path:
  - `dmem_we` = ms_valid && mem_we; held high every cycle until `dmem_wready`.
  - `dmem_waddr` = alu_result; `dmem_wdata` = store_data.
  - Exactly one accepted write per store instruction. Once accepted, the store completes even if `ws_allowin` is low.
  - A flag `store_done` suppresses re-issue while the stage is stalled on writeback.
- CSR path (cmd encodings in package):
  - W: wdata = op1.
  - S: wdata = csr_rdata | op1.
  - C: wdata = csr_rdata & ~op1.
  - Any other cmd: no write.
  - `csr_we` pulses once, on the cycle `ms_to_ws_valid && ws_allowin`. `csr_waddr` = csr_addr.
- Writeback select, by `wb_sel`:
  - 0: alu_result.
  - 1: load_data.
  - 2: pc+4, modulo 2^32.
  - 3: csr_rdata (the old value).
  - 4–7: 0.
- `rd_wen` on both output buses = latched rd_wen && ms_valid.

## Timing
- 1-cycle latency: an instruction accepted at edge N is visible on the outputs during cycle N+1.
- Reset values:
  - `ms_valid` = 0 and bus register = 0.
  - `dmem_we`, `csr_we`, `ms_to_ws_valid` = 0.
  - `ms_allowin` = 1.
  - Both output buses = 0.
- Store stall: `dmem_wready` low for k cycles gives k extra cycles in the stage. `ms_allowin` stays low throughout. Bus contents stay stable.
- Accept and drain in the same cycle is allowed: new bus loads at the edge where the old instruction leaves.
- Reset asserted mid-stall: `dmem_we` drops asynchronously and the instruction is discarded.
- `store_done` clears when the instruction leaves or on reset.

## Configuration
- `MS_CSR_EN` defined:
  - CSR path present as described.
  - wb_sel 3 returns csr_rdata.
- `MS_CSR_EN` undefined:
  - `csr_we` tied 0; `csr_waddr`/`csr_wdata` tied 0.
  - wb_sel 3 yields 0.
  - `csr_rdata` is ignored.

## Structure
- Shared package/header holds:
  - WB_SEL_ALU/MEM/PC4/CSR = 0..3.
  - CSR_CMD_X/W/S/C = 0..3.
  - Bus widths: 187, 70, 38.
- One sub-module, `csr_alu`: combinational cmd/rdata/op1 → we/wdata. Instantiated only under `MS_CSR_EN`.

## Test plan
- ALU op: rd=5, rd_wen=1, wb_sel=0, alu_result=0x1234, `ws_allowin`=1 → next cycle `ms_to_ws_valid`=1, `mem_wb_bus` wb_value=0x1234, rd=5.
- Store with `dmem_wready` low for 3 cycles: addr 0x100, data 0xDEADBEEF → `dmem_we` high for 4 cycles, `ms_allowin`=0 for 3 cycles, exactly one accepted write.
- Store accepted while `ws_allowin`=0 for 2 cycles → `dmem_we` low after acceptance, no second write.
- CSRRS: csr_rdata=0x0F, op1=0xF0, wb_sel=3 → `csr_wdata`=0xFF, single `csr_we` pulse, wb_value=0x0F.
- JAL-style: pc=0xFFFFFFFC, wb_sel=2 → wb_value=0x00000000 (wrap-around).
- Assert `rst` mid-store-stall → `dmem_we`=0 and `ms_valid`=0 immediately; `ms_allowin`=1.
